// File: rtl/polyvec_decompress_ctrl.sv
// Polyvec decompression sequencer: streams packed 10-bit ciphertext words
// through the decompress datapath and writes 12-bit results to polyvec memory.
module polyvec_decompress_ctrl #(
  parameter int KYBER_K = 2,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ct_rd_en,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [39:0]       ct_rdata,
  output logic [63:0]       dec_t,
  input  logic [47:0]       dec_r,
  output logic              pv_we,
  output logic [ADDR_W-1:0] pv_addr,
  output logic [47:0]       pv_wdata
);

  localparam int NWORDS = 64 * KYBER_K;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic              s1;
  logic              s2;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [47:0]       wdata_q;
  logic [63:0]       unpacked;

  always_comb begin
    unpacked = '0;
    for (int j = 0; j < 4; j++) begin
      unpacked[16*j +: 16] = {6'b0, ct_rdata[10*j +: 10]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ct_rd_en <= 1'b0;
      ct_addr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            ct_rd_en <= 1'b1;
            ct_addr  <= '0;
          end
        end
        RUN: begin
          if (ct_addr == LAST) begin
            state    <= DRAIN;
            ct_rd_en <= 1'b0;
          end else begin
            ct_addr <= ct_addr + 1'b1;
          end
        end
        DRAIN: begin
          // stage 3 holds the final write this cycle
          if (!s1 && !s2) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      pv_we   <= 1'b0;
      a1      <= '0;
      a2      <= '0;
      pv_addr <= '0;
      dec_t   <= '0;
      wdata_q <= '0;
    end else begin
      s1    <= ct_rd_en;
      s2    <= s1;
      pv_we <= s2;
      if (ct_rd_en) a1 <= ct_addr;
      if (s1) begin
        a2    <= a1;
        dec_t <= unpacked;
      end
      if (s2) pv_addr <= a2;
      if (pv_we) wdata_q <= dec_r;
    end
  end

  // datapath result is written the cycle it arrives; hold it otherwise
  assign pv_wdata = pv_we ? dec_r : wdata_q;

endmodule

// File: tb/tb_polyvec_decompress_ctrl.sv
// Scoreboard bench for polyvec_decompress_ctrl with ct memory
// and registered decompress datapath models.
module tb_polyvec_decompress_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        ct_rd_en;
  logic [6:0]  ct_addr;
  logic [39:0] ct_rdata = '0;
  logic [63:0] dec_t;
  logic [47:0] dec_r = '0;
  logic        pv_we;
  logic [6:0]  pv_addr;
  logic [47:0] pv_wdata;

  polyvec_decompress_ctrl #(.KYBER_K(2), .ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done),
    .ct_rd_en(ct_rd_en), .ct_addr(ct_addr), .ct_rdata(ct_rdata),
    .dec_t(dec_t), .dec_r(dec_r),
    .pv_we(pv_we), .pv_addr(pv_addr), .pv_wdata(pv_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] mem [128];

  function automatic logic [11:0] dc(input logic [15:0] c);
    logic [31:0] t;
    t = 32'(c) * 32'd3329 + 32'd512;
    return t[21:10];
  endfunction

  always @(posedge clk) if (ct_rd_en) ct_rdata <= mem[ct_addr];
  always @(posedge clk)
    dec_r <= {dc(dec_t[63:48]), dc(dec_t[47:32]),
              dc(dec_t[31:16]), dc(dec_t[15:0])};

  typedef struct {
    logic [6:0]  addr;
    logic [47:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int wr_cnt = 0;
  int busy_err = 0;
  int exp_done = -1;
  int run_lo = -1;
  int run_hi = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_we) begin
        exp_t e;
        wr_cnt++;
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d",
                   pv_addr, pv_wdata, cyc);
        end else begin
          e = q.pop_front();
          if (pv_addr != e.addr || pv_wdata != e.data || cyc != e.cyc)
            $display("FAIL write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                     pv_addr, pv_wdata, cyc, e.addr, e.data, e.cyc);
          else passes++;
        end
      end
      if (done) begin
        checks++;
        if (cyc != exp_done || busy)
          $display("FAIL done got cyc=%0d busy=%0b want cyc=%0d busy=0",
                   cyc, busy, exp_done);
        else passes++;
        exp_done = -1;
      end
      if (cyc >= run_lo && cyc <= run_hi && !busy) busy_err++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s got %h want %h", name, act, exp);
    else passes++;
  endtask

  function automatic logic [47:0] golden(input logic [39:0] w);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      r[12*j +: 12] = dc({6'b0, w[10*j +: 10]});
    return r;
  endfunction

  logic [47:0] hand [128];

  task automatic fill_random();
    for (int i = 0; i < 128; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      mem[i] = r[39:0];
      hand[i] = golden(mem[i]);
    end
  endtask

  // returns start cycle
  task automatic run_start(output int s);
    s = cyc;
    start = 1'b1;
    for (int i = 0; i < 128; i++) begin
      exp_t e;
      e.addr = 7'(i);
      e.data = hand[i];
      e.cyc  = s + 4 + i;
      q.push_back(e);
    end
    exp_done = s + 132;
    run_lo = s + 1;
    run_hi = s + 131;
    step();
    start = 1'b0;
  endtask

  int s;
  logic [9:0]  pat_c [4];
  logic [11:0] pat_r [4];

  initial begin
    pat_c[0] = 10'd0;  pat_c[1] = 10'd1;
    pat_c[2] = 10'd512; pat_c[3] = 10'd1023;
    pat_r[0] = 12'd0;  pat_r[1] = 12'd3;
    pat_r[2] = 12'd1665; pat_r[3] = 12'd3326;

    step();
    step();
    chk("reset_ctl", {60'b0, busy, done, ct_rd_en, pv_we}, 64'h0);
    chk("reset_addr", {50'b0, ct_addr, pv_addr}, 64'h0);
    chk("reset_dec_t", dec_t, 64'h0);
    chk("reset_wdata", {16'b0, pv_wdata}, 64'h0);
    rst_n = 1'b1;

    // run A: directed words, extra starts at +50 and +132 ignored
    fill_random();
    mem[0] = 40'hFF_C030_0801;
    hand[0] = {12'd3326, 12'd10, 12'd7, 12'd3};
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        mem[1+k][10*j +: 10] = pat_c[(j+k)%4];
        hand[1+k][12*j +: 12] = pat_r[(j+k)%4];
      end
    end
    wr_cnt = 0;
    busy_err = 0;
    run_start(s);
    wait_until(s + 3);
    chk("dec_t_word0", dec_t, 64'h03FF_0003_0002_0001);
    wait_until(s + 50);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_until(s + 132);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_until(s + 150);
    chk("runA_writes", 64'(wr_cnt), 64'd128);
    chk("runA_queue", 64'(q.size()), 64'd0);
    chk("runA_busy", 64'(busy_err), 64'd0);
    chk("runA_exp_done", 64'(exp_done), 64'hFFFF_FFFF_FFFF_FFFF);

    // run B aborted by reset at +60
    fill_random();
    run_start(s);
    wait_until(s + 60);
    rst_n = 1'b0;
    #1;
    chk("midreset_ctl", {60'b0, busy, done, ct_rd_en, pv_we}, 64'h0);
    chk("midreset_data", {dec_t[15:0], pv_wdata}, 64'h0);
    q.delete();
    exp_done = -1;
    run_hi = -1;
    step();
    step();
    rst_n = 1'b1;
    wr_cnt = 0;
    repeat (20) step();
    chk("post_reset_writes", 64'(wr_cnt), 64'd0);
    chk("post_reset_busy", {63'b0, busy}, 64'd0);

    // run C then run D started the cycle after done
    fill_random();
    wr_cnt = 0;
    busy_err = 0;
    run_start(s);
    wait_until(s + 133);
    chk("runC_writes", 64'(wr_cnt), 64'd128);
    fill_random();
    run_start(s);
    wait_until(s + 1);
    chk("runD_rd_en", {63'b0, ct_rd_en}, 64'd1);
    chk("runD_addr0", {57'b0, ct_addr}, 64'd0);
    wait_until(s + 150);
    chk("runCD_writes", 64'(wr_cnt), 64'd256);
    chk("runD_queue", 64'(q.size()), 64'd0);
    chk("runCD_busy", 64'(busy_err), 64'd0);
    chk("runD_exp_done", 64'(exp_done), 64'hFFFF_FFFF_FFFF_FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
